// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-SRAM write bus of the boot loader.
// slave = the loader, master = the stream source / SRAM side.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a big-endian, length-prefixed
// byte stream, packs bytes into 32-bit words and writes them to consecutive
// word addresses from BASE_ADDR. start_up holds fetch at the reset PC until
// the last word is written.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0020,
    parameter int          MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_loader_if.slave        bus,
    output logic                start_up,
    output logic                done,
    output logic                err,
    output logic [15:0]         words_written
);

    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_e;

    // 17 bits so a count of 65535 compares correctly against any limit
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_e      state_q, state_d;
    logic [7:0]  cnt_hi_q, cnt_hi_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] ww_q, ww_d;
    logic        xfer;

    // Handshake and status are pure decodes of the state register
    assign bus.in_ready  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) || (state_q == S_DATA);
    assign bus.mem_we    = (state_q == S_WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign start_up      = (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_ERR);
    assign words_written = ww_q;
    assign xfer          = bus.in_valid && bus.in_ready;

    // Next-state and datapath: header parse, byte packing, one-cycle write
    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ww_d       = ww_q;
        case (state_q)
            S_CNT_HI: begin
                if (xfer) begin
                    cnt_hi_d = bus.in_data;
                    state_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    count_d = {cnt_hi_q, bus.in_data};
                    if (count_d == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, count_d} > MAX_W) begin
                        state_d = S_ERR;
                    end else begin
                        byte_idx_d = 2'd0;
                        word_idx_d = 16'd0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = {word_q[23:0], bus.in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Capture address and data here so they are
                        // registered and stable for the WRITE cycle
                        wdata_d = word_d;
                        addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                ww_d       = ww_q + 16'd1;
                state_d    = (word_idx_d == count_q) ? S_DONE : S_DATA;
            end
            S_DONE, S_ERR: ;
            default: state_d = S_CNT_HI;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CNT_HI;
            cnt_hi_q   <= 8'd0;
            count_q    <= 16'd0;
            byte_idx_q <= 2'd0;
            word_idx_q <= 16'd0;
            word_q     <= 32'd0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            ww_q       <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_hi_q   <= cnt_hi_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ww_q       <= ww_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-count level reference model checked every
// cycle, plus literal end-of-stream expectations for the directed cases.
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0040_0020;
    localparam int          MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_up, done, err;
    logic [15:0] words_written;

    imem_loader_if bus ();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .start_up      (start_up),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks header bytes, data bytes and completed writes
    int          m_hdr, m_count, m_nd, m_written;
    bit          m_wr, m_done, m_err;
    logic [7:0]  m_hi;
    logic [31:0] m_addr, m_data;
    logic [7:0]  m_bytes[$];
    bit          exp_ready;
    bit          pend;
    logic [7:0]  pend_byte;
    logic [31:0] log_addr[$], log_data[$];

    // Compare process: advance model by what happened at the last edge, then check
    always @(negedge clk) begin
        if (!rst_n) begin
            m_hdr = 0; m_count = 0; m_nd = 0; m_written = 0;
            m_wr = 0; m_done = 0; m_err = 0; m_hi = 8'h00;
            m_addr = BASE; m_data = 32'h0;
            m_bytes.delete();
            log_addr.delete(); log_data.delete();
        end else begin
            if (m_wr) begin
                m_written++;
                m_wr = 0;
                if (m_written == m_count) m_done = 1;
            end
            if (pend) begin
                if (m_hdr == 0) begin
                    m_hi  = pend_byte;
                    m_hdr = 1;
                end else if (m_hdr == 1) begin
                    m_hdr   = 2;
                    m_count = {m_hi, pend_byte};
                    if (m_count == 0) m_done = 1;
                    else if (m_count > MAXW) m_err = 1;
                end else begin
                    m_bytes.push_back(pend_byte);
                    m_nd++;
                    if (m_nd % 4 == 0) begin
                        m_wr   = 1;
                        m_data = {m_bytes[m_nd-4], m_bytes[m_nd-3], m_bytes[m_nd-2], m_bytes[m_nd-1]};
                        m_addr = BASE + 32'(4 * (m_nd / 4 - 1));
                    end
                end
            end
        end
        exp_ready = !(m_done || m_err || m_wr);
        if (bus.mem_we === 1'b1) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_wdata);
        end
        check("cycle{rdy,we,su,done,err,ww,addr,data}",
              {43'd0, bus.in_ready, bus.mem_we, start_up, done, err, words_written, bus.mem_addr, bus.mem_wdata},
              {43'd0, exp_ready, m_wr, !m_done, m_done, m_err, 16'(m_written), m_addr, m_data});
        pend      = rst_n && bus.in_valid && exp_ready;
        pend_byte = bus.in_data;
    end

    // Present one byte after an optional random gap; bounded wait for acceptance
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int  g;
        bit  acc;
        g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        repeat (g) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: byte %h not accepted within 40 cycles", b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] q[$], input int gap_max);
        foreach (q[i]) send_byte(q[i], gap_max);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    task automatic check_end(input string name, input int n_wr, input bit e_done, input bit e_err, input int e_ww);
        check({name, ".writes"}, 128'(log_addr.size()), 128'(n_wr));
        check({name, ".done"},   128'(done),     128'(e_done));
        check({name, ".err"},    128'(err),      128'(e_err));
        check({name, ".start_up"}, 128'(start_up), 128'(!e_done));
        check({name, ".ww"},     128'(words_written), 128'(e_ww));
    endtask

    initial begin
        logic [7:0] q[$];
        int         cnt;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        // reset values
        check("reset.in_ready", 128'(bus.in_ready), 128'(1));
        check("reset.mem_addr", 128'(bus.mem_addr), 128'(32'h0040_0020));
        rst_n = 1'b1;

        // single word, in_valid held high
        q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_stream(q, 0);
        idle(3);
        check_end("single", 1, 1, 0, 1);
        if (log_addr.size() > 0) begin
            check("single.addr", 128'(log_addr[0]), 128'(32'h0040_0020));
            check("single.data", 128'(log_data[0]), 128'(32'hDEADBEEF));
        end

        // three words with random gaps
        do_reset();
        q = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
              8'h33, 8'h33, 8'h33, 8'h33};
        send_stream(q, 3);
        idle(3);
        check_end("three", 3, 1, 0, 3);
        if (log_addr.size() == 3) begin
            check("three.addr2", 128'(log_addr[2]), 128'(32'h0040_0028));
            check("three.data1", 128'(log_data[1]), 128'(32'h22222222));
        end

        // zero count
        do_reset();
        q = '{8'h00, 8'h00};
        send_stream(q, 0);
        check_end("zero", 0, 1, 0, 0);

        // over-range count: data bytes offered but never taken
        do_reset();
        q = '{8'h00, 8'h05};
        send_stream(q, 0);
        bus.in_valid = 1'b1;
        repeat (10) begin bus.in_data = 8'($urandom); @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        check_end("over", 0, 0, 1, 0);
        check("over.in_ready", 128'(bus.in_ready), 128'(0));

        // high count byte alone puts it out of range
        do_reset();
        q = '{8'h01, 8'h00};
        send_stream(q, 0);
        idle(2);
        check_end("over_hi", 0, 0, 1, 0);

        // exactly MAX_WORDS words, back-to-back, order under back-pressure
        do_reset();
        q = '{8'h00, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4,
              8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        send_stream(q, 0);
        idle(3);
        check_end("max", 4, 1, 0, 4);
        if (log_addr.size() == 4) begin
            check("max.data1", 128'(log_data[1]), 128'(32'hB1B2B3B4));
            check("max.addr3", 128'(log_addr[3]), 128'(32'h0040_002C));
        end

        // reset mid-word then a fresh stream
        do_reset();
        q = '{8'h00, 8'h02, 8'h55, 8'h66};
        send_stream(q, 0);
        do_reset();
        q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        send_stream(q, 1);
        idle(3);
        check_end("midrst", 1, 1, 0, 1);
        if (log_addr.size() > 0) begin
            check("midrst.addr", 128'(log_addr[0]), 128'(32'h0040_0020));
            check("midrst.data", 128'(log_data[0]), 128'(32'hCAFEBABE));
        end

        // randomized streams, including zero and over-range counts
        for (int it = 0; it < 10; it++) begin
            int gap;
            do_reset();
            cnt = $urandom_range(0, 5);
            gap = $urandom_range(0, 3);
            q = '{8'h00, 8'(cnt)};
            if (cnt <= MAXW)
                for (int i = 0; i < 4 * cnt; i++) q.push_back(8'($urandom));
            send_stream(q, gap);
            idle(3);
            if (cnt > MAXW) check_end("rand_err", 0, 0, 1, 0);
            else            check_end("rand", cnt, 1, 0, cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes instruction memory before the fetch stage starts running. It accepts a length-prefixed byte stream on a valid/ready interface and packs each group of four bytes into a 32-bit word. Each word is written into instruction SRAM at consecutive word addresses starting at the reset PC. While loading it holds `start_up` high, which keeps the fetch stage's PC pinned to the reset PC. It releases `start_up` once the last word has been written.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0040_0020: byte address of the first written word (the fetch reset PC); bits [1:0] must be 0.
- `MAX_WORDS`, default 1024: largest accepted word count.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  one-cycle write strobe to instruction SRAM.
- `mem_addr`  out  32  write byte address; bits [1:0] are always 0.
- `mem_wdata`  out  32  write data.
- `start_up`  out  1  high while loading; feeds the fetch PC mux select.
- `done`  out  1  load finished successfully; sticky.
- `err`  out  1  word count out of range; sticky.
- `words_written`  out  16  count of completed SRAM writes.

## Operation
- Stream format, all big-endian: `cnt_hi`, `cnt_lo`, then `4 × count` data bytes. Within each group, the first byte goes to `wdata[31:24]`.
- A byte transfers on a rising edge where `in_valid && in_ready`. Nothing happens without `in_valid`, and the loader keeps its state indefinitely.
- States:
  - CNT_HI: `in_ready=1`. On a transfer, latch the high count byte and go to CNT_LO.
  - CNT_LO: `in_ready=1`. On a transfer, form the 16-bit count.
    - count == 0: go to DONE.
    - count > MAX_WORDS: go to ERR.
    - otherwise: clear the byte index and word index, then go to DATA.
  - DATA: `in_ready=1`. On a transfer, shift the byte into the word assembly register and increment the 2-bit byte index. After the 4th byte, go to WRITE.
  - WRITE: `in_ready=0`, `mem_we=1` for exactly one cycle.
    - `mem_addr = BASE_ADDR + (word_index << 2)` (32-bit add, wraps modulo 2^32).
    - `mem_wdata` is the assembled word.
    - On the next edge: increment `word_index` and `words_written`. If `word_index + 1 == count`, go to DONE; else go to DATA.
  - DONE: `in_ready=0`, `start_up=0`, `done=1`. Terminal until reset.
  - ERR: `in_ready=0`, `start_up=1`, `err=1`. No SRAM writes. Terminal until reset; the fetch stage stays held.
- `mem_addr` and `mem_wdata` are registered and remain stable outside WRITE. `mem_we` is the only qualifier the SRAM sees.
- Bytes presented in WRITE, DONE or ERR are not consumed.

## Timing
- Reset (`rst_n=0`, asynchronous) forces:
  - state = CNT_HI, `in_ready=1`, `start_up=1`.
  - `mem_we=0`, `mem_addr=BASE_ADDR`, `mem_wdata=0`.
  - `done=0`, `err=0`, `words_written=0`.
  - Applies mid-load too: partially assembled words are discarded, and the next stream restarts at `cnt_hi`.
- Reset release takes effect synchronously on the first rising edge with `rst_n=1`.
- Throughput: with `in_valid` held high, each word takes 5 cycles (4 byte cycles plus 1 WRITE cycle).
- The write for word *k* occurs in the cycle after its 4th byte is accepted.
- `start_up` falls in the cycle after the final WRITE cycle, i.e. the same cycle `done` rises.
- Zero count: `start_up` falls one cycle after `cnt_lo` is accepted.
- `in_ready` is a function of state only. It never depends combinationally on `in_valid`.
- `words_written` saturates naturally at the count; it never exceeds MAX_WORDS.

## Test plan
- Single word: stream 00 01 DE AD BE EF with `in_valid` always high. Require:
  - exactly one `mem_we` pulse with addr 0x0040_0020, data 0xDEADBEEF;
  - `start_up` 1→0 and `done`=1 the next cycle;
  - `words_written`=1.
- Three words with random `in_valid` gaps: words 0x11111111, 0x22222222, 0x33333333. Require writes to 0x0040_0020, 0x0040_0024, 0x0040_0028 in order, with no `in_ready` during any WRITE cycle.
- Zero count: stream 00 00. Require no `mem_we`; `done`=1 and `start_up`=0 one cycle after the 2nd byte.
- Over-range count with MAX_WORDS=4: stream 00 05 plus data. Require `err`=1, `start_up` stays 1, no writes, `in_ready`=0 thereafter.
- Reset mid-word: assert `rst_n`=0 after 2 data bytes of word 1, then send 00 01 CA FE BA BE. Require a single write of 0xCAFEBABE to 0x0040_0020 and `words_written`=1.
- Back-pressure: hold `in_valid`=1 with a new byte pending during WRITE. Require the byte is not consumed until the cycle after WRITE, and the data order is preserved.
